jtag_ir_unit: RTL and testbench
===============================

JTAG_IR_UNIT -- requirements
Module: jtag_ir_unit

Interface
REQ-001 SHALL have parameter IR_W, default 5, instruction register width (min 2).
REQ-002 SHALL have parameter IDCODE_VAL, default 32'h1000_0001, device ID (bit0 = 1).
REQ-003 tck  input  1  JTAG test clock.
REQ-004 trst  input  1  reset, asynchronous, active-low.
REQ-005 tdi  input  1  serial test data in.
REQ-006 tap_reset  input  1  high in Test-Logic-Reset (TAP controller output).
REQ-007 capture_ir / shift_ir / update_ir  input  1 each  TAP IR-state qualifiers (levels).
REQ-008 capture_dr / shift_dr / update_dr  input  1 each  TAP DR-state qualifiers (levels).
REQ-009 select  input  1  1 = IR path, 0 = DR path, for the TDO mux.
REQ-010 tdo_en_in  input  1  TAP shift-enable, already falling-edge registered.
REQ-011 user_tdo  input  1  serial out of the external user DR.
REQ-012 user_capture / user_shift / user_update  output  1 each  user DR qualifiers, active only while USER is decoded.
REQ-013 ir_out  output  IR_W  current (shadow) instruction.
REQ-014 tdo  output  1  serial test data out.
REQ-015 tdo_oe  output  1  tdo output enable.

Function
REQ-016 The IR shift stage SHALL use posedge tck:
- capture_ir: load {0..0, 2'b01}.
- shift_ir: load {tdi, ir_sr[IR_W-1:1]}.
- otherwise: hold.
REQ-017 The shadow IR SHALL load ir_sr on negedge tck while update_ir = 1.
REQ-018 tap_reset = 1 SHALL force the shadow IR to IDCODE on negedge tck, with priority over update_ir.
REQ-019 Opcode decode (package constants, IR_W = 5):
- IDCODE = 5'b00001.
- USER = 5'b00010.
- BYPASS = all-ones.
- Every other opcode SHALL decode as BYPASS.
REQ-020 The bypass register SHALL be 1 bit, updated on posedge tck:
- capture_dr: load 0.
- shift_dr: load tdi.
- Enabled only when BYPASS is decoded.
REQ-021 The IDCODE register SHALL be 32 bits, updated on posedge tck:
- capture_dr: load IDCODE_VAL.
- shift_dr: shift right with tdi into bit 31.
- Enabled only when IDCODE is decoded.
REQ-022 The user_* outputs SHALL be combinational: the respective *_dr input AND (USER decoded).
REQ-023 The TDO mux SHALL select:
- select = 1: ir_sr[0].
- select = 0 with IDCODE decoded: id_sr[0].
- select = 0 with USER decoded: user_tdo.
- select = 0 otherwise: bypass bit.
REQ-024 tdo SHALL be the mux output registered on negedge tck, so each bit is stable across the following posedge.
REQ-025 tdo_oe SHALL equal tdo_en_in, passed through combinationally with no added latency.
REQ-026 If capture and shift qualifiers are asserted together, capture SHALL take priority; the TAP never produces this case.
REQ-027 The decoded instruction SHALL change only at the shadow update, never during an IR shift.
REQ-028 An IR scan of N ≠ IR_W shifts SHALL leave ir_sr holding the last IR_W bits shifted in.

Reset
REQ-029 trst low SHALL asynchronously set:
- ir_sr = {0.., 2'b01}.
- shadow IR = IDCODE.
- bypass = 0.
- id_sr = IDCODE_VAL.
- tdo = 0.
REQ-030 trst assertion mid-scan SHALL abort the scan; the next DR scan after release SHALL return IDCODE_VAL.
REQ-031 tap_reset SHALL reset only the shadow IR (REQ-018); it does not touch the shift registers.

Structure
REQ-032 Package jtag_pkg SHALL hold:
- IR_W default.
- Opcode localparams: IDCODE, USER, BYPASS.
- Default IDCODE_VAL.
- Enum instr_e {I_BYPASS, I_IDCODE, I_USER}.
REQ-033 The module SHALL instantiate generic sub-module jtag_shift_reg (params W, CAPTURE_VAL; ports capture, shift, tdi, q) for the IR stage and the IDCODE register.
REQ-034 There SHALL be no gated clocks: all storage uses tck edges with enables.

Verification
REQ-035 Release trst, then DR scan 32 shifts with no IR scan -> tdo bits LSB-first equal 32'h1000_0001.
REQ-036 IR scan shifting in 5'b11111 -> tdo emits capture pattern 1,0,0,0,0; after update, a DR scan of 0xA5 followed by 0 -> 0xA5 appears on tdo delayed by exactly 1 tck.
REQ-037 IR scan of 5'b10110 (unused opcode) -> behaves as BYPASS, giving a 1-cycle delay.
REQ-038 IR scan of USER -> user_shift tracks shift_dr; tdo follows user_tdo with one negedge register stage; user_update pulses during update_dr.
REQ-039 Assert tap_reset for 1 tck after loading USER -> ir_out = 5'b00001 at the next negedge.
REQ-040 Pulse trst low mid-IR-shift -> ir_out = IDCODE and ir_sr = 5'b00001 immediately (async); the following DR scan returns IDCODE_VAL.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared JTAG instruction-register definitions.
// Opcodes are given at the default 5-bit IR width.
package jtag_pkg;

    localparam int IR_W_DEF = 5;

    localparam logic [IR_W_DEF-1:0] IDCODE = 5'b00001;
    localparam logic [IR_W_DEF-1:0] USER   = 5'b00010;
    localparam logic [IR_W_DEF-1:0] BYPASS = 5'b11111;

    localparam logic [31:0] IDCODE_VAL_DEF = 32'h1000_0001;

    typedef enum logic [1:0] {
        I_BYPASS,
        I_IDCODE,
        I_USER
    } instr_e;

endpackage

// File: rtl/jtag_shift_reg.sv
// Generic capture/shift register, LSB shifted out, tdi into the MSB.
// The reset value equals the capture value.
module jtag_shift_reg #(
    parameter int           W           = 5,
    parameter logic [W-1:0] CAPTURE_VAL = '0
) (
    input  logic         tck,
    input  logic         trst,
    input  logic         capture,
    input  logic         shift,
    input  logic         tdi,
    output logic [W-1:0] q
);

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            q <= CAPTURE_VAL;
        end else if (capture) begin
            q <= CAPTURE_VAL;
        end else if (shift) begin
            q <= {tdi, q[W-1:1]};
        end
    end

endmodule

// File: rtl/jtag_ir_unit.sv
// JTAG instruction register with IDCODE, BYPASS and USER data paths
// and the negedge-registered TDO mux.
module jtag_ir_unit
    import jtag_pkg::*;
#(
    parameter int          IR_W       = IR_W_DEF,
    parameter logic [31:0] IDCODE_VAL = IDCODE_VAL_DEF
) (
    input  logic            tck,
    input  logic            trst,
    input  logic            tdi,
    input  logic            tap_reset,
    input  logic            capture_ir,
    input  logic            shift_ir,
    input  logic            update_ir,
    input  logic            capture_dr,
    input  logic            shift_dr,
    input  logic            update_dr,
    input  logic            select,
    input  logic            tdo_en_in,
    input  logic            user_tdo,
    output logic            user_capture,
    output logic            user_shift,
    output logic            user_update,
    output logic [IR_W-1:0] ir_out,
    output logic            tdo,
    output logic            tdo_oe
);

    localparam logic [IR_W-1:0] IR_CAP    = IR_W'(2'b01);
    localparam logic [IR_W-1:0] OP_IDCODE = IR_W'(IDCODE);
    localparam logic [IR_W-1:0] OP_USER   = IR_W'(USER);

    logic [IR_W-1:0] ir_sr;
    logic [IR_W-1:0] ir_q;
    logic [31:0]     id_sr;
    logic            bypass;
    logic            tdo_d;
    instr_e          instr;

    jtag_shift_reg #(
        .W           (IR_W),
        .CAPTURE_VAL (IR_CAP)
    ) u_ir_sr (
        .tck     (tck),
        .trst    (trst),
        .capture (capture_ir),
        .shift   (shift_ir),
        .tdi     (tdi),
        .q       (ir_sr)
    );

    jtag_shift_reg #(
        .W           (32),
        .CAPTURE_VAL (IDCODE_VAL)
    ) u_id_sr (
        .tck     (tck),
        .trst    (trst),
        .capture (capture_dr && instr == I_IDCODE),
        .shift   (shift_dr && instr == I_IDCODE),
        .tdi     (tdi),
        .q       (id_sr)
    );

    // Shadow IR changes on the falling edge so the decode is stable
    // across the whole following rising edge.
    always_ff @(negedge tck or negedge trst) begin
        if (!trst) begin
            ir_q <= OP_IDCODE;
        end else if (tap_reset) begin
            ir_q <= OP_IDCODE;
        end else if (update_ir) begin
            ir_q <= ir_sr;
        end
    end

    always_comb begin
        instr = I_BYPASS;
        unique case (1'b1)
            (ir_q == OP_IDCODE): instr = I_IDCODE;
            (ir_q == OP_USER):   instr = I_USER;
            default:             instr = I_BYPASS;
        endcase
    end

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            bypass <= 1'b0;
        end else if (instr == I_BYPASS) begin
            if (capture_dr) begin
                bypass <= 1'b0;
            end else if (shift_dr) begin
                bypass <= tdi;
            end
        end
    end

    assign user_capture = capture_dr && instr == I_USER;
    assign user_shift   = shift_dr && instr == I_USER;
    assign user_update  = update_dr && instr == I_USER;

    always_comb begin
        tdo_d = bypass;
        if (select) begin
            tdo_d = ir_sr[0];
        end else if (instr == I_IDCODE) begin
            tdo_d = id_sr[0];
        end else if (instr == I_USER) begin
            tdo_d = user_tdo;
        end
    end

    always_ff @(negedge tck or negedge trst) begin
        if (!trst) begin
            tdo <= 1'b0;
        end else begin
            tdo <= tdo_d;
        end
    end

    assign ir_out = ir_q;
    assign tdo_oe = tdo_en_in;

endmodule

// File: tb/tb_jtag_ir_unit.sv
// Directed bench for jtag_ir_unit: IR/DR scans driven cycle by cycle,
// outputs sampled just after each falling edge.
module tb_jtag_ir_unit;
    import jtag_pkg::*;

    logic       tck = 1'b0;
    logic       trst, tdi, tap_reset;
    logic       capture_ir, shift_ir, update_ir;
    logic       capture_dr, shift_dr, update_dr;
    logic       select, tdo_en_in, user_tdo;
    logic       user_capture, user_shift, user_update;
    logic [4:0] ir_out;
    logic       tdo, tdo_oe;

    int pass_cnt = 0;
    int total    = 0;

    localparam logic [31:0] ID = 32'h1000_0001;

    jtag_ir_unit dut (
        .tck          (tck),
        .trst         (trst),
        .tdi          (tdi),
        .tap_reset    (tap_reset),
        .capture_ir   (capture_ir),
        .shift_ir     (shift_ir),
        .update_ir    (update_ir),
        .capture_dr   (capture_dr),
        .shift_dr     (shift_dr),
        .update_dr    (update_dr),
        .select       (select),
        .tdo_en_in    (tdo_en_in),
        .user_tdo     (user_tdo),
        .user_capture (user_capture),
        .user_shift   (user_shift),
        .user_update  (user_update),
        .ir_out       (ir_out),
        .tdo          (tdo),
        .tdo_oe       (tdo_oe)
    );

    always #5 tck = ~tck;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            pass_cnt++;
    endtask

    // One TAP cycle: drive, rising edge, falling edge, settle.
    task automatic step(input logic ci, si, ui, cd, sd, ud,
                        input logic tr, sel, d, ut);
        capture_ir = ci; shift_ir = si; update_ir = ui;
        capture_dr = cd; shift_dr = sd; update_dr = ud;
        tap_reset = tr; select = sel; tdi = d; user_tdo = ut;
        @(posedge tck);
        @(negedge tck);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic ir_shift(input logic [15:0] bits, input int n,
                            output logic [4:0] cap);
        cap = '0;
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        cap[0] = tdo;
        for (int i = 0; i < n; i++) begin
            step(0, 1, 0, 0, 0, 0, 0, 1, bits[i], 0);
            if (i < 4) cap[i+1] = tdo;
        end
    endtask

    task automatic ir_update();
        step(0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic dr_byte(input logic [7:0] d, output logic cap,
                           output logic [7:0] got);
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        cap = tdo;
        for (int k = 0; k < 8; k++) begin
            step(0, 0, 0, 0, 1, 0, 0, 0, d[k], 0);
            got[k] = tdo;
        end
        step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    endtask

    task automatic dr_32(output logic [31:0] got);
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        got[0] = tdo;
        for (int k = 0; k < 31; k++) begin
            step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
            got[k+1] = tdo;
        end
        step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    endtask

    typedef struct {
        logic [4:0] ir;
        logic [7:0] d;
        logic       cap;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [4:0]  cap_pat;
        logic [4:0]  cur_ir;
        logic        cap_bit;
        logic [7:0]  got8;
        logic [31:0] got32;

        vecs[0] = '{5'b11111, 8'hA5, 1'b0, 8'hA5};
        vecs[1] = '{5'b10110, 8'h3C, 1'b0, 8'h3C};
        vecs[2] = '{5'b00001, 8'hFF, 1'b1, ID[8:1]};
        vecs[3] = '{5'b00000, 8'h5A, 1'b0, 8'h5A};
        vecs[4] = '{5'b11100, 8'h81, 1'b0, 8'h81};

        trst = 1'b0; tdo_en_in = 1'b0;
        capture_ir = 0; shift_ir = 0; update_ir = 0;
        capture_dr = 0; shift_dr = 0; update_dr = 0;
        tap_reset = 0; select = 0; tdi = 0; user_tdo = 0;
        @(negedge tck);
        #1;
        chk("reset_tdo", 32'(tdo), 32'd0);
        chk("reset_ir_out", 32'(ir_out), 32'h01);
        chk("reset_ir_sr", 32'(dut.ir_sr), 32'h01);

        tdo_en_in = 1'b1;
        #1 chk("tdo_oe_1", 32'(tdo_oe), 32'd1);
        tdo_en_in = 1'b0;
        #1 chk("tdo_oe_0", 32'(tdo_oe), 32'd0);

        trst = 1'b1;
        idle();
        dr_32(got32);
        chk("idcode_after_reset", got32, ID);
        cur_ir = 5'b00001;

        foreach (vecs[v]) begin
            ir_shift(16'(vecs[v].ir), 5, cap_pat);
            chk($sformatf("v%0d_ir_capture", v), 32'(cap_pat), 32'h01);
            chk($sformatf("v%0d_ir_hold", v), 32'(ir_out), 32'(cur_ir));
            ir_update();
            chk($sformatf("v%0d_ir_out", v), 32'(ir_out), 32'(vecs[v].ir));
            cur_ir = vecs[v].ir;
            dr_byte(vecs[v].d, cap_bit, got8);
            chk($sformatf("v%0d_dr_cap", v), 32'(cap_bit), 32'(vecs[v].cap));
            chk($sformatf("v%0d_dr_data", v), 32'(got8), 32'(vecs[v].exp));
        end

        step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        chk("no_user_shift_in_bypass", 32'(user_shift), 32'd0);

        // 7-bit IR scan; last five bits in are 00010 (USER).
        ir_shift(16'h000B, 7, cap_pat);
        ir_update();
        chk("long_scan_user", 32'(ir_out), 32'h02);

        step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        chk("user_capture", 32'(user_capture), 32'd1);
        chk("user_shift_idle", 32'(user_shift), 32'd0);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        chk("user_shift", 32'(user_shift), 32'd1);
        chk("user_tdo_1", 32'(tdo), 32'd1);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        chk("user_tdo_0", 32'(tdo), 32'd0);
        step(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        chk("user_tdo_1b", 32'(tdo), 32'd1);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("user_update", 32'(user_update), 32'd1);
        chk("user_shift_off", 32'(user_shift), 32'd0);

        // tap_reset wins over a simultaneous update of USER.
        step(0, 0, 1, 0, 0, 0, 1, 1, 0, 0);
        chk("tap_reset_ir", 32'(ir_out), 32'h01);

        ir_shift(16'h0002, 5, cap_pat);
        ir_update();
        chk("reload_user", 32'(ir_out), 32'h02);

        ir_shift(16'h001F, 2, cap_pat);
        trst = 1'b0;
        #1;
        chk("trst_ir_out", 32'(ir_out), 32'h01);
        chk("trst_ir_sr", 32'(dut.ir_sr), 32'h01);
        chk("trst_tdo", 32'(tdo), 32'd0);
        shift_ir = 0; select = 0; tdi = 0;
        @(negedge tck);
        #1 trst = 1'b1;
        idle();
        dr_32(got32);
        chk("idcode_after_trst", got32, ID);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
